// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU control sequencer and the datapath blocks that
// decode its control bus: control-bit indices, opcodes and micro-step encoding.
package cpu_ctrl_pkg;

    // Control-bus bit indices (bits 12 and 15 are reserved and always 0)
    localparam int unsigned CS_MAR_PC  = 0;   // MAR <- PC
    localparam int unsigned CS_MBR_MEM = 1;   // MBR <- mem[MAR]
    localparam int unsigned CS_IR_MBR  = 2;   // IR  <- MBR[15:8]
    localparam int unsigned CS_MAR_MBR = 3;   // MAR <- MBR[7:0]
    localparam int unsigned CS_PC_INC  = 4;   // PC  <- PC + 1
    localparam int unsigned CS_MBR_ACC = 5;   // MBR <- ACC
    localparam int unsigned CS_MEM_MBR = 6;   // mem[MAR] <- MBR
    localparam int unsigned CS_BR_MBR  = 7;   // BR  <- MBR
    localparam int unsigned CS_ACC_CLR = 8;   // ACC <- 0
    localparam int unsigned CS_PC_MBR  = 9;   // PC  <- MBR[7:0]
    localparam int unsigned CS_ACC_ADD = 10;  // ACC <- ACC + BR
    localparam int unsigned CS_ACC_SUB = 11;  // ACC <- ACC - BR
    localparam int unsigned CS_ACC_AND = 13;  // ACC <- ACC & BR
    localparam int unsigned CS_ACC_OR  = 14;  // ACC <- ACC | BR

    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [7:0] OP_STORE  = 8'h01;
    localparam logic [7:0] OP_LOAD   = 8'h02;
    localparam logic [7:0] OP_ADD    = 8'h03;
    localparam logic [7:0] OP_SUB    = 8'h04;
    localparam logic [7:0] OP_JMPGEZ = 8'h05;
    localparam logic [7:0] OP_JMP    = 8'h06;
    localparam logic [7:0] OP_HALT   = 8'h07;
    localparam logic [7:0] OP_AND    = 8'h0A;
    localparam logic [7:0] OP_OR     = 8'h0B;

    typedef enum logic [3:0] {
        StBoot = 4'd0,
        StF0   = 4'd1,
        StF1   = 4'd2,
        StF2   = 4'd3,
        StE0   = 4'd4,
        StE1   = 4'd5,
        StE2   = 4'd6,
        StHalt = 4'd7
    } step_e;

    // One-hot control word with a single bit set
    function automatic logic [15:0] cs_bit(input int unsigned idx);
        logic [15:0] w;
        w = '0;
        w[idx[3:0]] = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/cpu_ctrl_rom.sv
// Combinational microcode ROM. Given the current micro-step and the opcode /
// ACC sign that apply to it, selects the next micro-step and the control word
// that step must drive.
//   step_i       : current micro-step
//   opcode_i     : opcode of the instruction being sequenced
//   acc_neg_i    : ACC sign bit latched for this instruction
//   next_step_o  : micro-step to enter at the next transition
//   next_word_o  : control word for next_step_o
module cpu_ctrl_rom
    import cpu_ctrl_pkg::*;
(
    input  step_e       step_i,
    input  logic [7:0]  opcode_i,
    input  logic        acc_neg_i,
    output step_e       next_step_o,
    output logic [15:0] next_word_o
);

    logic is_alu;
    logic is_mem;
    logic is_jump;

    assign is_alu  = (opcode_i == OP_ADD) || (opcode_i == OP_SUB) ||
                     (opcode_i == OP_AND) || (opcode_i == OP_OR);
    assign is_mem  = (opcode_i == OP_LOAD) || is_alu;  // three-step memory-read ops
    assign is_jump = (opcode_i == OP_JMP) || (opcode_i == OP_JMPGEZ);

    always_comb begin
        next_step_o = StF0;
        case (step_i)
            StBoot: next_step_o = StF0;
            StF0:   next_step_o = StF1;
            StF1:   next_step_o = StF2;
            StF2: begin
                if (opcode_i == OP_HALT) begin
                    next_step_o = StHalt;
                end else if (is_mem || is_jump || (opcode_i == OP_STORE)) begin
                    next_step_o = StE0;
                end else begin
                    next_step_o = StF0;
                end
            end
            StE0:   next_step_o = (is_mem || (opcode_i == OP_STORE)) ? StE1 : StF0;
            StE1:   next_step_o = is_mem ? StE2 : StF0;
            StE2:   next_step_o = StF0;
            StHalt: next_step_o = StHalt;
            default: next_step_o = StBoot;
        endcase
    end

    always_comb begin
        next_word_o = '0;
        case (next_step_o)
            StF0: next_word_o = cs_bit(CS_MAR_PC);
            StF1: next_word_o = cs_bit(CS_MBR_MEM) | cs_bit(CS_PC_INC);
            StF2: next_word_o = cs_bit(CS_IR_MBR) | cs_bit(CS_MAR_MBR);
            StE0: begin
                if (opcode_i == OP_STORE) begin
                    next_word_o = cs_bit(CS_MBR_ACC);
                end else if (is_mem) begin
                    next_word_o = cs_bit(CS_MBR_MEM);
                end else if ((opcode_i == OP_JMP) || !acc_neg_i) begin
                    // MBR still holds the instruction, so its low byte is the target
                    next_word_o = cs_bit(CS_PC_MBR);
                end
            end
            StE1: begin
                if (opcode_i == OP_STORE) begin
                    next_word_o = cs_bit(CS_MEM_MBR);
                end else if (opcode_i == OP_LOAD) begin
                    next_word_o = cs_bit(CS_BR_MBR) | cs_bit(CS_ACC_CLR);
                end else begin
                    next_word_o = cs_bit(CS_BR_MBR);
                end
            end
            StE2: begin
                case (opcode_i)
                    OP_SUB:  next_word_o = cs_bit(CS_ACC_SUB);
                    OP_AND:  next_word_o = cs_bit(CS_ACC_AND);
                    OP_OR:   next_word_o = cs_bit(CS_ACC_OR);
                    default: next_word_o = cs_bit(CS_ACC_ADD);  // ADD, and LOAD adds BR to 0
                endcase
            end
            default: next_word_o = '0;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl_seq.sv
// Microprogrammed control sequencer. Steps each instruction through fetch and
// execute micro-steps, holding every control word for exactly two cycles.
//   clk                : system clock, rising edge
//   rst_n              : asynchronous active-low reset
//   ir_opcode_i        : IR contents (instruction bits [15:8])
//   acc_neg_i          : ACC sign bit
//   control_signals_o  : registered 16-bit control word
//   halted_o           : registered, high while halted
//   step_dbg_o         : current micro-step encoding
module cpu_ctrl_seq
    import cpu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ir_opcode_i,
    input  logic        acc_neg_i,
    output logic [15:0] control_signals_o,
    output logic        halted_o,
    output logic [3:0]  step_dbg_o
);

    step_e       step_q, step_d;
    logic        phase_q, phase_d;
    logic [15:0] cs_q, cs_d;
    logic        halted_q, halted_d;
    logic [7:0]  op_q, op_d;
    logic        neg_q, neg_d;

    step_e       rom_next_step;
    logic [15:0] rom_next_word;
    logic [7:0]  rom_opcode;
    logic        rom_acc_neg;

    // Inputs are live only while leaving F2; later steps use the latched copy
    assign rom_opcode  = (step_q == StF2) ? ir_opcode_i : op_q;
    assign rom_acc_neg = (step_q == StF2) ? acc_neg_i   : neg_q;

    cpu_ctrl_rom u_rom (
        .step_i      (step_q),
        .opcode_i    (rom_opcode),
        .acc_neg_i   (rom_acc_neg),
        .next_step_o (rom_next_step),
        .next_word_o (rom_next_word)
    );

    always_comb begin
        phase_d  = ~phase_q;
        step_d   = step_q;
        cs_d     = cs_q;
        halted_d = halted_q;
        op_d     = op_q;
        neg_d    = neg_q;
        // Transition only on the second cycle of a step
        if (phase_q) begin
            step_d   = rom_next_step;
            cs_d     = rom_next_word;
            halted_d = (rom_next_step == StHalt);
            if (step_q == StF2) begin
                op_d  = ir_opcode_i;
                neg_d = acc_neg_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q   <= StBoot;
            phase_q  <= 1'b0;
            cs_q     <= '0;
            halted_q <= 1'b0;
            op_q     <= '0;
            neg_q    <= 1'b0;
        end else begin
            step_q   <= step_d;
            phase_q  <= phase_d;
            cs_q     <= cs_d;
            halted_q <= halted_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
        end
    end

    assign control_signals_o = cs_q;
    assign halted_o          = halted_q;
    assign step_dbg_o        = step_q;

endmodule
